// File: rtl/xor_nn_seq_ctrl.sv
// Sequencer for the 2-2-1 XOR inference network: one shared signed fixed-point multiplier
// stepped through six multiply-accumulate cycles, with valid/ready in and out.
module xor_nn_seq_ctrl #(
  parameter int unsigned W    = 32,
  parameter int unsigned FRAC = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] x0,
  input  logic [W-1:0] x1,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] pred,
  output logic         busy,
  input  logic         cfg_we,
  input  logic [3:0]   cfg_addr,
  input  logic [W-1:0] cfg_data
);

  localparam int unsigned NumPrm = 9;
  localparam int unsigned IdxW00 = 0;
  localparam int unsigned IdxW01 = 1;
  localparam int unsigned IdxBh0 = 2;
  localparam int unsigned IdxW10 = 3;
  localparam int unsigned IdxW11 = 4;
  localparam int unsigned IdxBh1 = 5;
  localparam int unsigned IdxWo0 = 6;
  localparam int unsigned IdxWo1 = 7;
  localparam int unsigned IdxBo  = 8;

  typedef enum logic [1:0] {StIdle, StMac, StDone} state_e;

  state_e       state_q, state_d;
  logic [2:0]   step_q, step_d;
  logic [W-1:0] x0_q, x0_d, x1_q, x1_d;
  logic [W-1:0] h0_q, h0_d, h1_q, h1_d;
  logic [W-1:0] acc_q, acc_d, pred_q, pred_d;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] prm_q [NumPrm];
  logic [W-1:0] prm_d [NumPrm];

  logic [W-1:0]          mul_a, mul_b, add_op;
  logic signed [2*W-1:0] mul_a_ext, mul_b_ext, prod, prod_sh;
  logic [W-1:0]          mul_res, sum, sum_relu;

  // Operand select: multiplier inputs are forced to zero outside MAC so it stays idle.
  always_comb begin
    mul_a  = '0;
    mul_b  = '0;
    add_op = '0;
    if (state_q == StMac) begin
      case (step_q)
        3'd0: begin mul_a = prm_q[IdxW00]; mul_b = x0_q; add_op = prm_q[IdxBh0]; end
        3'd1: begin mul_a = prm_q[IdxW01]; mul_b = x1_q; add_op = h0_q;          end
        3'd2: begin mul_a = prm_q[IdxW10]; mul_b = x0_q; add_op = prm_q[IdxBh1]; end
        3'd3: begin mul_a = prm_q[IdxW11]; mul_b = x1_q; add_op = h1_q;          end
        3'd4: begin mul_a = prm_q[IdxWo0]; mul_b = h0_q; add_op = prm_q[IdxBo];  end
        3'd5: begin mul_a = prm_q[IdxWo1]; mul_b = h1_q; add_op = acc_q;         end
        default: begin mul_a = '0; mul_b = '0; add_op = '0; end
      endcase
    end
  end

  assign mul_a_ext = {{W{mul_a[W-1]}}, mul_a};
  assign mul_b_ext = {{W{mul_b[W-1]}}, mul_b};
  assign prod      = mul_a_ext * mul_b_ext;
  // Arithmetic shift floors toward minus infinity, e.g. -0.5 LSB becomes -1.
  assign prod_sh   = prod >>> FRAC;
  assign mul_res   = prod_sh[W-1:0];
  assign sum       = add_op + mul_res;
  assign sum_relu  = sum[W-1] ? '0 : sum;

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    x0_d        = x0_q;
    x1_d        = x1_q;
    h0_d        = h0_q;
    h1_d        = h1_q;
    acc_d       = acc_q;
    pred_d      = pred_q;
    out_valid_d = out_valid_q;
    for (int i = 0; i < NumPrm; i++) begin
      prm_d[i] = prm_q[i];
    end

    unique case (state_q)
      StIdle: begin
        if (cfg_we) begin
          for (int i = 0; i < NumPrm; i++) begin
            if (cfg_addr == 4'(i)) prm_d[i] = cfg_data;
          end
        end
        if (in_valid) begin
          x0_d    = x0;
          x1_d    = x1;
          step_d  = 3'd0;
          state_d = StMac;
        end
      end
      StMac: begin
        step_d = step_q + 3'd1;
        case (step_q)
          3'd0: h0_d  = sum;
          3'd1: h0_d  = sum_relu;
          3'd2: h1_d  = sum;
          3'd3: h1_d  = sum_relu;
          3'd4: acc_d = sum;
          3'd5: begin
            pred_d      = sum;
            out_valid_d = 1'b1;
            step_d      = 3'd0;
            state_d     = StDone;
          end
          default: begin
            step_d  = 3'd0;
            state_d = StIdle;
          end
        endcase
      end
      StDone: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      step_q      <= '0;
      x0_q        <= '0;
      x1_q        <= '0;
      h0_q        <= '0;
      h1_q        <= '0;
      acc_q       <= '0;
      pred_q      <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < NumPrm; i++) begin
        prm_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      x0_q        <= x0_d;
      x1_q        <= x1_d;
      h0_q        <= h0_d;
      h1_q        <= h1_d;
      acc_q       <= acc_d;
      pred_q      <= pred_d;
      out_valid_q <= out_valid_d;
      for (int i = 0; i < NumPrm; i++) begin
        prm_q[i] <= prm_d[i];
      end
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign out_valid = out_valid_q;
  assign pred      = pred_q;

endmodule

// File: doc/xor_nn_seq_ctrl.md
# xor_nn_seq_ctrl

Sequencer for the 2-2-1 XOR inference network. It accepts one input pair over a valid/ready handshake and time-multiplexes a single signed multiplier across all six multiply-accumulate steps: two hidden neurons with ReLU, then one linear output neuron. It returns a signed fixed-point prediction over a second valid/ready handshake. The nine network parameters sit in an internal register file loaded through a simple write port. The block sits between the host/UART front end and the prediction consumer, and replaces the fully parallel combinational datapath.

## Interface
Parameters:
- W, 32, data and parameter width, signed two's complement.
- FRAC, 16, fractional bits of the fixed-point format (1.0 = 2^FRAC).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous and active-high.
- in_valid  in  1  input pair x0/x1 valid.
- in_ready  out  1  block can accept an input pair.
- x0, x1  in  W  signed fixed-point inputs.
- out_valid  out  1  pred valid.
- out_ready  in  1  consumer accepts pred.
- pred  out  W  signed fixed-point prediction.
- busy  out  1  high in every state except IDLE.
- cfg_we  in  1  parameter write strobe.
- cfg_addr  in  4  parameter index: 0 w00, 1 w01, 2 b_h0, 3 w10, 4 w11, 5 b_h1, 6 wo0, 7 wo1, 8 b_o.
- cfg_data  in  W  parameter value.

## Operation
- States: IDLE, MAC (step counter 0..5), DONE.
- in_ready = (state == IDLE). An accept (in_valid && in_ready) latches x0 and x1, clears the step counter and moves to MAC.
- mul(a,b): full 2W-bit signed product, arithmetic shift right by FRAC (floor), keep the low W bits. Sums are W-bit two's complement and wrap; no saturation.
- MAC steps, one per cycle, one multiplier use per step:
  - Step 0: h0 <= b_h0 + mul(w00,x0).
  - Step 1: h0 <= relu(h0 + mul(w01,x1)).
  - Step 2: h1 <= b_h1 + mul(w10,x0).
  - Step 3: h1 <= relu(h1 + mul(w11,x1)).
  - Step 4: acc <= b_o + mul(wo0,h0).
  - Step 5: pred <= acc + mul(wo1,h1); out_valid <= 1; state <= DONE.
- relu(v) = 0 if v is negative (MSB set), otherwise v.
- DONE: pred and out_valid hold stable until out_valid && out_ready; then out_valid <= 0 and state <= IDLE. pred keeps its last value after the handshake.
- Config writes take effect only in IDLE. Index 0..8 writes that register on the edge. cfg_we outside IDLE, or with cfg_addr >= 9, is silently dropped.
- If cfg_we and an input accept occur on the same IDLE edge, both take effect; the accepted inference uses the new value.

## Timing
- Reset (async assert, sync use on release): state IDLE, in_ready 1, busy 0, out_valid 0, pred 0, h0/h1/acc 0, all nine parameters 0.
- Accept on edge E0 → MAC steps on edges E1..E5 → pred and out_valid registered on E6. Latency from accept to out_valid is 6 cycles.
- With out_ready held high, the output handshake is on E7, in_ready is high after E7, and the next accept is on E8. Peak throughput is one inference per 8 cycles.
- in_valid while busy is ignored; the upstream holds its data until in_ready.
- Asserting rst during MAC or DONE aborts immediately. Outputs return to reset values, no out_valid pulse is produced, and parameters are cleared.
- At most one multiplier operation per cycle; the multiplier is idle in IDLE and DONE.

## Test plan
- Reset check: assert rst mid-run. Required: in_ready=1, busy=0, out_valid=0, pred=0 asynchronously, before the next clock edge. After release, an input (1.0, 1.0) with all-zero parameters gives pred=0.
- XOR truth table: load w00=w01=w10=w11=65536, b_h0=0, b_h1=-65536, wo0=65536, wo1=-131072, b_o=0. Inputs (0,0), (65536,0), (0,65536), (65536,65536) give pred 0, 65536, 65536, 0. out_valid rises exactly 6 cycles after each accept.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid. Required: pred and out_valid stable, in_ready=0, in_valid pulses ignored. Releasing out_ready gives one handshake and in_ready=1 on the following cycle.
- Config while busy: write cfg_addr=8 (b_o) with 0x7FFFFFFF during MAC. Required: write dropped and the next inference is unchanged. A cfg_addr=12 write in IDLE changes nothing.
- Arithmetic edge cases:
  - w00=32768 (0.5), x0=-1, other parameters zero except wo0=65536. Required: mul rounds by floor to -1, relu gives h0=0, pred=0.
  - b_o=0x7FFFFFFF with wo0·h0 = +1. Required: pred wraps to 0x80000000.
- Reset mid-inference: assert rst on the cycle after step 2. Required: out_valid never asserts, in_ready=1 after release, parameters read back as zero (a subsequent inference gives pred=0).
